// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_pkg : shared types and configuration checks for the UART transmitter
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // True when the elaboration parameters describe a buildable transmitter.
    function automatic bit cfg_ok(int cpb, int db, int pe, int po, int sb, int depth);
        return (cpb >= 2) && (db >= 5) && (db <= 9) &&
               (pe == 0 || pe == 1) && (po == 0 || po == 1) &&
               (sb == 1 || sb == 2) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_tx_fifo : synchronous word FIFO with combinational head and occupancy
// Revision     : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             w_push;
    logic             w_pop;

    // Full/empty come from the registered count only, so a push while full is
    // dropped even when a pop happens in the same cycle.
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = mem_q[rptr_q];
    assign count  = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + 1'b1;
            if (w_pop)  rptr_q <= rptr_q + 1'b1;
            if (w_push && !w_pop)      count_q <= count_q + 1'b1;
            else if (w_pop && !w_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wptr_q] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_tx_frame : buffered UART transmitter, configurable data/parity/stop bits
// Revision      : 1.0
// ============================================================================
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DATA_BITS-1:0]          data_in,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int                BIT_W     = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_INIT  = (PARITY_ODD != 0);

    if (!cfg_ok(CLKS_PER_BIT, DATA_BITS, PARITY_EN, PARITY_ODD, STOP_BITS, FIFO_DEPTH)) begin : g_bad_cfg
        $error("uart_tx_frame: illegal parameter combination");
    end

    uart_tx_state_t        state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  tick;
    logic                  load;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_BITS-1:0]  fifo_rdata;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (start),
        .pop   (fifo_pop),
        .wdata (data_in),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ready = !fifo_full;
    assign tx    = tx_q;
    assign busy  = (state_q != IDLE);
    assign tick  = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        load     = 1'b0;
        fifo_pop = 1'b0;

        if (state_q == IDLE) baud_d = '0;
        else                 baud_d = tick ? '0 : baud_q + 1'b1;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) load = 1'b1;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_q == STOP_LAST) begin
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Popping the head also launches the start bit, giving gap-free frames.
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            parity_d = (^fifo_rdata) ^ PAR_INIT;
            state_d  = START;
            tx_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_tx_frame : scoreboard bench for two transmitter configurations
//                    (8N1 and 7 data / odd parity / 2 stop)
// Revision         : 1.0
// ============================================================================
module tb_uart_tx_frame;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    // One expected frame: acceptance edge, first edge of the start bit,
    // length in cycles and the line value of every bit in order.
    typedef struct {
        int          a;
        int          s;
        int          len;
        logic [15:0] bits;
    } frame_t;

    int db_c [2] = '{8, 7};
    int pe_c [2] = '{0, 1};
    int po_c [2] = '{0, 1};
    int sb_c [2] = '{1, 2};

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          st0  = 1'b0;
    logic          st1  = 1'b0;
    logic [7:0]    din0 = '0;
    logic [6:0]    din1 = '0;
    logic [1:0]    rdy;
    logic [1:0]    txl;
    logic [1:0]    bsy;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    int     cyc      = 0;
    int     checks   = 0;
    int     failures = 0;
    bit     mon_en   = 1'b0;
    frame_t sb [2][$];
    int     last_s [2] = '{-100000, -100000};

    uart_tx_frame #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY_EN (0),
        .PARITY_ODD (0), .STOP_BITS (1), .FIFO_DEPTH (DEPTH)
    ) dut0 (
        .clk (clk), .rst (rst), .start (st0), .data_in (din0),
        .ready (rdy[0]), .tx (txl[0]), .busy (bsy[0]), .fifo_count (cnt0)
    );

    uart_tx_frame #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (7), .PARITY_EN (1),
        .PARITY_ODD (1), .STOP_BITS (2), .FIFO_DEPTH (DEPTH)
    ) dut1 (
        .clk (clk), .rst (rst), .start (st1), .data_in (din1),
        .ready (rdy[1]), .tx (txl[1]), .busy (bsy[1]), .fifo_count (cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    function automatic frame_t mk_frame(int i, int d, int a, int s);
        frame_t f;
        int     p;
        f.a       = a;
        f.s       = s;
        f.len     = (1 + db_c[i] + pe_c[i] + sb_c[i]) * CPB;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        p         = po_c[i];
        for (int b = 0; b < db_c[i]; b++) begin
            f.bits[1 + b] = ((d >> b) & 1) != 0;
            p = p ^ ((d >> b) & 1);
        end
        if (pe_c[i] != 0) f.bits[1 + db_c[i]] = (p & 1) != 0;
        return f;
    endfunction

    // Words accepted by edge t whose frame has not started by edge t.
    function automatic int model_count(int i, int t);
        int n = 0;
        for (int k = 0; k < sb[i].size(); k++)
            if (sb[i][k].a <= t && sb[i][k].s > t) n++;
        return n;
    endfunction

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", name, i, cyc, act, want);
        end
    endtask

    // Called at a falling edge; the write is seen by the next rising edge.
    task automatic drive(int i, bit v, int d);
        int s;
        int flen;
        if (i == 0) begin st0 = v; din0 = 8'(d); end
        else        begin st1 = v; din1 = 7'(d); end
        if (v && model_count(i, cyc) != DEPTH) begin
            flen = (1 + db_c[i] + pe_c[i] + sb_c[i]) * CPB;
            s = cyc + 2;
            if (last_s[i] + flen > s) s = last_s[i] + flen;
            sb[i].push_back(mk_frame(i, d, cyc + 1, s));
            last_s[i] = s;
        end
    endtask

    task automatic step(bit v0, int d0, bit v1, int d1);
        drive(0, v0, d0);
        drive(1, v1, d1);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 3000) begin
            step(0, 0, 0, 0);
            n++;
        end
        if (sb[0].size() != 0 || sb[1].size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout cyc=%0d actual=pending required=empty", cyc);
        end
        repeat (5) step(0, 0, 0, 0);
    endtask

    // Three words from idle, then a fourth timed to land on the edge that
    // ends the first frame's stop phase, with two words still queued.
    task automatic collide(int i);
        for (int n = 0; n < 3; n++) begin
            if (i == 0) step(1, int'($urandom_range(0, 255)), 0, 0);
            else        step(0, 0, 1, int'($urandom_range(0, 127)));
        end
        while (cyc < sb[i][0].s + sb[i][0].len - 1) step(0, 0, 0, 0);
        if (i == 0) step(1, 'h3C, 0, 0);
        else        step(0, 0, 1, 'h55);
        drain();
    endtask

    // Monitor: retire finished frames, then compare the line against the model.
    always @(negedge clk) begin
        logic [31:0] etx;
        logic [31:0] ebusy;
        int          k;
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                while (sb[i].size() > 0 && sb[i][0].s + sb[i][0].len <= cyc)
                    void'(sb[i].pop_front());
                etx   = 1;
                ebusy = 0;
                if (sb[i].size() > 0 && sb[i][0].s <= cyc) begin
                    k     = (cyc - sb[i][0].s) / CPB;
                    etx   = 32'(sb[i][0].bits[k]);
                    ebusy = 1;
                end
                chk("tx", i, 32'(txl[i]), etx);
                chk("busy", i, 32'(bsy[i]), ebusy);
                chk("fifo_count", i, (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'(model_count(i, cyc)));
                chk("ready", i, 32'(rdy[i]), (model_count(i, cyc) != DEPTH) ? 32'd1 : 32'd0);
            end
        end
    end

    initial begin
        #1 rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        repeat (100) step(0, 0, 0, 0);

        step(1, 'hA5, 1, 'h03);
        repeat (60) step(0, 0, 0, 0);

        for (int n = 0; n < 6; n++)
            step(1, int'($urandom_range(0, 255)), 1, int'($urandom_range(0, 127)));
        drain();

        collide(0);
        collide(1);

        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 255)),
                 $urandom_range(0, 3) == 0, int'($urandom_range(0, 127)));
        drain();

        for (int n = 0; n < 3; n++)
            step(1, int'($urandom_range(0, 255)), 1, int'($urandom_range(0, 127)));
        while (cyc < sb[0][0].s + 3 * CPB + 1) step(0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx", i, 32'(txl[i]), 32'd1);
            chk("rst_busy", i, 32'(bsy[i]), 32'd0);
            chk("rst_ready", i, 32'(rdy[i]), 32'd1);
            chk("rst_count", i, (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'd0);
            sb[i].delete();
            last_s[i] = -100000;
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        repeat (200) step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
